ps2_scan_decoder: RTL and testbench
===================================

# ps2_scan_decoder

Consumes the byte stream from the PS/2 receive stage (one `rx_done_tick` strobe per received byte) and decodes Set-2 scan-code sequences (`E0`, `F0`, `E0 F0` prefixes) into key events: code, make/break and extended flags. Events are buffered in a small first-word-fall-through FIFO with a valid/ready handshake toward the application logic. The block also tracks modifier state (Shift, Ctrl, Alt, Caps Lock).

## Interface
- `FIFO_DEPTH`, 4, event FIFO entries; power of 2, ≥2.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `rx_done_tick`  in  1  one-cycle strobe: `rx_data` holds a new byte.
- `rx_data`  in  8  received byte, valid while `rx_done_tick`=1.
- `evt_valid`  out  1  FIFO non-empty.
- `evt_ready`  in  1  consumer accepts head event when `evt_valid`&`evt_ready`.
- `evt_code`  out  8  head event scan code (0 when empty).
- `evt_break`  out  1  head event is a release (0 when empty).
- `evt_ext`  out  1  head event had `E0` prefix (0 when empty).
- `shift`, `ctrl`, `alt`  out  1 each  key currently held (left OR right).
- `caps_lock`  out  1  Caps Lock toggle state.
- `drop_tick`  out  1  one-cycle pulse: event lost, FIFO full.

## Operation
- All state acts only on cycles with `rx_done_tick`=1; otherwise the FSM and modifiers hold.
- FSM states: IDLE, EXT, BRK, EXT_BRK. Reset → IDLE.
- Control bytes `AA`, `FA`, `EE`, `FE`, `00`, `FF` in any state: no event, FSM → IDLE.
- IDLE: `E0`→EXT; `F0`→BRK; other byte → emit {byte, break=0, ext=0}, stay IDLE.
- EXT: `F0`→EXT_BRK; `E0`→stay EXT; other → emit {byte, 0, 1}, →IDLE.
- BRK: `E0`→EXT_BRK; `F0`→stay BRK; other → emit {byte, 1, 0}, →IDLE.
- EXT_BRK: `E0`/`F0` → stay; other → emit {byte, 1, 1}, →IDLE.
- Modifiers update on every emit, whether or not the FIFO accepts the event. Four internal held bits (lshift `12`, rshift `59`, ctrl `14`, alt `11`); ext flag ignored for these codes. Make sets the bit, break clears it. `shift` = lshift|rshift.
- Caps: code `58` non-ext. Make toggles `caps_lock` only if internal `caps_held`=0, then sets `caps_held`; break clears `caps_held`. Typematic repeats therefore do not re-toggle.
- FIFO push on emit. Pop on `evt_valid`&`evt_ready`. Full and push with no pop: event discarded, `drop_tick`. Full with simultaneous push and pop: both occur, no drop. Empty: `evt_ready` ignored.

## Timing
- Reset values: `evt_valid`, `evt_code`, `evt_break`, `evt_ext`, `shift`, `ctrl`, `alt`, `caps_lock`, `drop_tick` all 0. FIFO empty, FSM IDLE, held bits 0.
- Reset mid-sequence (e.g. after `E0`) returns to IDLE; a partial prefix is never completed.
- Emit latency: the event is written at the clock edge that samples `rx_done_tick`. `evt_valid`/`evt_*` show it in the next cycle (1 cycle). Modifiers update at the same edge.
- `drop_tick` is registered and high in the cycle after the rejected push.
- Pop takes effect at the edge. The next head appears in the following cycle; back-to-back pops allowed every cycle.
- Pointers wrap modulo `FIFO_DEPTH`. The counter distinguishes full from empty (width log2(FIFO_DEPTH)+1).
- Minimum `rx_done_tick` spacing is not assumed; strobes on consecutive cycles are handled.

## Test plan
- Bytes `1C`, `F0 1C` with `evt_ready`=1: events {1C,0,0} then {1C,1,0}. Prefix bytes produce no event. `evt_valid` high 1 cycle after each final tick.
- `E0 75`, `E0 F0 75`, `E0 E0 F0 F0 6B`: events {75,0,1}, {75,1,1}, {6B,1,1}.
- `12`, `59`, `F0 12`: `shift`=1, 1, still 1. Then `F0 59`: `shift`=0. `E0 14`: `ctrl`=1.
- `58 58 58 F0 58 58`: `caps_lock` 1 after the first make and stays 1 through the repeats and the release. The next make gives 0.
- `evt_ready`=0, six make codes, `FIFO_DEPTH`=4: first four retained in order; `drop_tick` pulses twice. Then a full FIFO with a push on the same cycle as a pop: no drop, order preserved.
- `E0`, reset pulse, `1C`: event {1C,0,0}. Also `AA` in BRK: no event, next `1C` gives a make.

Source files
------------

// File: rtl/ps2_scan_decoder_if.sv
// rtl/ps2_scan_decoder_if.sv - key event stream between the scan decoder and its consumer
interface ps2_scan_decoder_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_break;
  logic       evt_ext;

  modport master (
    output evt_valid,
    output evt_code,
    output evt_break,
    output evt_ext,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_break,
    input  evt_ext,
    output evt_ready
  );
endinterface

// File: rtl/ps2_scan_decoder.sv
// rtl/ps2_scan_decoder.sv - PS/2 Set-2 scan-code decoder with modifier tracking and event FIFO
module ps2_scan_decoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_done_tick,
  input  logic [7:0]             rx_data,
  ps2_scan_decoder_if.master     evt,
  output logic                   shift,
  output logic                   ctrl,
  output logic                   alt,
  output logic                   caps_lock,
  output logic                   drop_tick
);

  localparam int            AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);

  localparam logic [7:0] B_EXT    = 8'hE0;
  localparam logic [7:0] B_BRK    = 8'hF0;
  localparam logic [7:0] K_LSHIFT = 8'h12;
  localparam logic [7:0] K_RSHIFT = 8'h59;
  localparam logic [7:0] K_CTRL   = 8'h14;
  localparam logic [7:0] K_ALT    = 8'h11;
  localparam logic [7:0] K_CAPS   = 8'h58;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK
  } state_e;

  state_e state_q, state_d;

  logic emit;
  logic emit_brk;
  logic emit_ext;
  logic is_ctrl_byte;

  logic lshift_q, lshift_d;
  logic rshift_q, rshift_d;
  logic ctrl_q, ctrl_d;
  logic alt_q, alt_d;
  logic caps_held_q, caps_held_d;
  logic caps_lock_q, caps_lock_d;
  logic drop_q, drop_d;

  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [9:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic [9:0] head;

  // Keyboard status/ack bytes abort any partial prefix and never become events.
  assign is_ctrl_byte = (rx_data == 8'hAA) || (rx_data == 8'hFA) || (rx_data == 8'hEE) ||
                        (rx_data == 8'hFE) || (rx_data == 8'h00) || (rx_data == 8'hFF);

  always_comb begin
    state_d  = state_q;
    emit     = 1'b0;
    emit_brk = 1'b0;
    emit_ext = 1'b0;
    if (rx_done_tick) begin
      if (is_ctrl_byte) begin
        state_d = S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (rx_data == B_EXT)      state_d = S_EXT;
            else if (rx_data == B_BRK) state_d = S_BRK;
            else                       emit    = 1'b1;
          end
          S_EXT: begin
            if (rx_data == B_BRK) begin
              state_d = S_EXT_BRK;
            end else if (rx_data != B_EXT) begin
              emit     = 1'b1;
              emit_ext = 1'b1;
              state_d  = S_IDLE;
            end
          end
          S_BRK: begin
            if (rx_data == B_EXT) begin
              state_d = S_EXT_BRK;
            end else if (rx_data != B_BRK) begin
              emit     = 1'b1;
              emit_brk = 1'b1;
              state_d  = S_IDLE;
            end
          end
          S_EXT_BRK: begin
            if ((rx_data != B_EXT) && (rx_data != B_BRK)) begin
              emit     = 1'b1;
              emit_brk = 1'b1;
              emit_ext = 1'b1;
              state_d  = S_IDLE;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // Modifiers follow every decoded event, even one the FIFO has to drop.
  always_comb begin
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    ctrl_d      = ctrl_q;
    alt_d       = alt_q;
    caps_held_d = caps_held_q;
    caps_lock_d = caps_lock_q;
    if (emit) begin
      case (rx_data)
        K_LSHIFT: lshift_d = ~emit_brk;
        K_RSHIFT: rshift_d = ~emit_brk;
        K_CTRL:   ctrl_d   = ~emit_brk;
        K_ALT:    alt_d    = ~emit_brk;
        K_CAPS: begin
          if (!emit_ext) begin
            if (!emit_brk) begin
              if (!caps_held_q) caps_lock_d = ~caps_lock_q;
              caps_held_d = 1'b1;
            end else begin
              caps_held_d = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);
  assign pop        = ~fifo_empty & evt.evt_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign push       = emit & (~fifo_full | pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    drop_d   = emit & fifo_full & ~pop;
    if (push) mem_d[wr_ptr_q] = {rx_data, emit_brk, emit_ext};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      ctrl_q      <= 1'b0;
      alt_q       <= 1'b0;
      caps_held_q <= 1'b0;
      caps_lock_q <= 1'b0;
      drop_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      ctrl_q      <= ctrl_d;
      alt_q       <= alt_d;
      caps_held_q <= caps_held_d;
      caps_lock_q <= caps_lock_d;
      drop_q      <= drop_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mem_q       <= mem_d;
    end
  end

  assign head = fifo_empty ? 10'd0 : mem_q[rd_ptr_q];

  assign evt.evt_valid = ~fifo_empty;
  assign evt.evt_code  = head[9:2];
  assign evt.evt_break = head[1];
  assign evt.evt_ext   = head[0];

  assign shift     = lshift_q | rshift_q;
  assign ctrl      = ctrl_q;
  assign alt       = alt_q;
  assign caps_lock = caps_lock_q;
  assign drop_tick = drop_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// tb/tb_ps2_scan_decoder.sv - randomized bench for ps2_scan_decoder against a behavioural model
module tb_ps2_scan_decoder;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       shift, ctrl, alt, caps_lock, drop_tick;

  ps2_scan_decoder_if evt ();

  ps2_scan_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .evt          (evt.master),
    .shift        (shift),
    .ctrl         (ctrl),
    .alt          (alt),
    .caps_lock    (caps_lock),
    .drop_tick    (drop_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: prefix flags, a queue of {code,break,ext}, and a key-down table.
  bit         m_ext, m_brk;
  logic [9:0] m_q [$];
  bit         down [256];
  bit         m_caps, m_caps_down;
  bit         m_drop;
  int         drops_seen;

  logic [7:0] mod_keys  [5] = '{8'h12, 8'h59, 8'h14, 8'h11, 8'h58};
  logic [7:0] ctl_bytes [6] = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
  logic [7:0] fill_keys [6] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};

  function automatic void model_reset();
    m_ext = 0; m_brk = 0;
    m_q.delete();
    for (int i = 0; i < 256; i++) down[i] = 0;
    m_caps = 0; m_caps_down = 0; m_drop = 0;
  endfunction

  function automatic void apply_mods(logic [7:0] b, bit brk, bit ext);
    if (b == 8'h12 || b == 8'h59 || b == 8'h14 || b == 8'h11) down[b] = !brk;
    if (b == 8'h58 && !ext) begin
      if (!brk) begin
        if (!m_caps_down) m_caps = !m_caps;
        m_caps_down = 1;
      end else begin
        m_caps_down = 0;
      end
    end
  endfunction

  task automatic check_outputs();
    logic [9:0] head;
    head = (m_q.size() != 0) ? m_q[0] : 10'd0;
    check("valid", 32'(evt.evt_valid), 32'(m_q.size() != 0));
    check("head", 32'({evt.evt_code, evt.evt_break, evt.evt_ext}), 32'(head));
    check("mods", 32'({shift, ctrl, alt, caps_lock}),
          32'({down[8'h12] | down[8'h59], down[8'h14], down[8'h11], m_caps}));
    check("drop", 32'(drop_tick), 32'(m_drop));
    if (drop_tick) drops_seen++;
  endtask

  task automatic step(input bit tick, input logic [7:0] b, input bit rdy);
    bit         emit, pop;
    logic [9:0] ev;
    @(negedge clk);
    rx_done_tick  = tick;
    rx_data       = b;
    evt.evt_ready = rdy;
    pop  = (m_q.size() != 0) && rdy;
    emit = 0;
    ev   = '0;
    if (tick) begin
      if (b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE || b == 8'h00 || b == 8'hFF) begin
        m_ext = 0; m_brk = 0;
      end else if (b == 8'hE0) begin
        m_ext = 1;
      end else if (b == 8'hF0) begin
        m_brk = 1;
      end else begin
        emit = 1;
        ev   = {b, m_brk, m_ext};
        apply_mods(b, m_brk, m_ext);
        m_ext = 0; m_brk = 0;
      end
    end
    m_drop = emit && (m_q.size() == DEPTH) && !pop;
    if (pop) void'(m_q.pop_front());
    if (emit && !m_drop) m_q.push_back(ev);
    @(posedge clk);
    #1;
    check_outputs();
    rx_done_tick = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    step(1, b, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b1;
    rx_done_tick = 1'b0;
    model_reset();
    #1;
    check("rst_valid", 32'(evt.evt_valid), 32'd0);
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    rx_done_tick  = 1'b0;
    rx_data       = 8'h00;
    evt.evt_ready = 1'b0;
    drops_seen    = 0;
    model_reset();
    do_reset();

    send(8'h1C); send(8'hF0); send(8'h1C); idle(2);
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'hE0); send(8'hF0); send(8'hF0); send(8'h6B); idle(2);

    send(8'h12); send(8'h59); send(8'hF0); send(8'h12);
    check("shift_held", 32'(shift), 32'd1);
    send(8'hF0); send(8'h59);
    check("shift_rel", 32'(shift), 32'd0);
    send(8'hE0); send(8'h14);
    check("ctrl_ext", 32'(ctrl), 32'd1);

    send(8'h58);
    check("caps_first", 32'(caps_lock), 32'd1);
    send(8'h58); send(8'h58); send(8'hF0); send(8'h58); idle(1);
    check("caps_repeat", 32'(caps_lock), 32'd1);
    send(8'h58);
    check("caps_second", 32'(caps_lock), 32'd0);
    idle(6);

    drops_seen = 0;
    for (int i = 0; i < 6; i++) step(1, fill_keys[i], 0);
    check("drop_count", 32'(drops_seen), 32'd2);
    step(1, 8'h34, 1);
    check("full_pushpop_drop", 32'(drop_tick), 32'd0);
    idle(6);

    send(8'hE0);
    do_reset();
    send(8'h1C);
    check("post_rst_head", 32'({evt.evt_code, evt.evt_break, evt.evt_ext}), 32'({8'h1C, 2'b00}));
    idle(2);
    send(8'hF0); send(8'hAA); send(8'h1C);
    check("ctl_abort_head", 32'({evt.evt_code, evt.evt_break, evt.evt_ext}), 32'({8'h1C, 2'b00}));
    idle(2);

    for (int n = 0; n < 3000; n++) begin
      int         r;
      logic [7:0] b;
      r = int'($urandom_range(0, 99));
      if (r < 15)      b = 8'hE0;
      else if (r < 30) b = 8'hF0;
      else if (r < 45) b = mod_keys[$urandom_range(0, 4)];
      else if (r < 50) b = ctl_bytes[$urandom_range(0, 5)];
      else             b = 8'($urandom_range(0, 255));
      if (n == 1500) do_reset();
      step(($urandom_range(0, 9) < 6), b, ($urandom_range(0, 1) == 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
